// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the VGA pixel pipeline. The sprite index
// fetcher and the palette decoder both use this package.
//   color_idx_t             3-bit palette index
//   H_ACTIVE / V_ACTIVE     visible screen size in pixels
//   COORD_W                 width of the pixel coordinate buses
//   DEFAULT_BG_IDX          index used for background and blanking
//   DEFAULT_TRANSP_IDX      ROM index that is treated as see-through
// ---------------------------------------------------------------------------
package vga_pkg;

   typedef logic [2:0] color_idx_t;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int COORD_W  = 10;

   localparam color_idx_t DEFAULT_BG_IDX     = 3'd0;
   localparam color_idx_t DEFAULT_TRANSP_IDX = 3'd5;

endpackage

// File: rtl/vga_sync_delay.sv
// ---------------------------------------------------------------------------
// vga_sync_delay
// A shift register with a configurable depth and width. It delays side-band
// signals such as the syncs and the inside flag so that they line up with
// the pixel data path. A synchronous reset loads RESET_VAL into every stage.
//   clk    pixel clock
//   rst    synchronous, active-high reset
//   din    value entering the pipeline
//   dout   din delayed by DEPTH clock cycles
// ---------------------------------------------------------------------------
module vga_sync_delay #(
   parameter int               DEPTH     = 2,
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stages [DEPTH];

   // Stage 0 takes the new input. Each later stage takes the value from the
   // stage before it. On reset every stage is filled with the idle value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stages[i] <= RESET_VAL;
         end
      end else begin
         stages[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stages[i] <= stages[i-1];
         end
      end
   end

   assign dout = stages[DEPTH-1];

endmodule

// File: rtl/sprite_index_fetch.sv
// ---------------------------------------------------------------------------
// sprite_index_fetch
// Places a 160x120 image of 3-bit indices, held in an external synchronous
// ROM, on the 640x480 screen. The image is scaled up 4x and its position is
// set at runtime. The module outputs one colour index per pixel, plus syncs
// that are aligned with that index, to the palette decoder.
// Pipeline:
//   E1  latch the address
//   E2  the ROM reads
//   E3  pick the colour
//   Total latency: 3 cycles.
//   clk, rst                 pixel clock, synchronous active-high reset
//   pix_x, pix_y             current pixel from the timing generator
//   video_on, hsync_in,
//   vsync_in                 timing generator flags (syncs are active low)
//   frame_start              pulse that loads pos_x_req/pos_y_req
//   pos_x_req, pos_y_req     requested top-left corner of the window
//   rom_addr, rom_data       synchronous ROM port (data arrives 1 cycle later)
//   color_idx                colour index for the palette decoder
//   hsync_out, vsync_out,
//   video_on_out             timing flags delayed to match color_idx
// ---------------------------------------------------------------------------
module sprite_index_fetch
   import vga_pkg::*;
#(
   parameter int         IMG_W      = 160,
   parameter int         IMG_H      = 120,
   parameter int         SCALE_LOG2 = 2,
   parameter int         ADDR_W     = 15,
   parameter color_idx_t BG_IDX     = DEFAULT_BG_IDX,
   parameter color_idx_t TRANSP_IDX = DEFAULT_TRANSP_IDX
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   input  logic               video_on,
   input  logic               hsync_in,
   input  logic               vsync_in,
   input  logic               frame_start,
   input  logic [COORD_W-1:0] pos_x_req,
   input  logic [COORD_W-1:0] pos_y_req,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [2:0]         rom_data,
   output color_idx_t         color_idx,
   output logic               hsync_out,
   output logic               vsync_out,
   output logic               video_on_out
);

   // Size of the window on screen, after upscaling.
   localparam logic [COORD_W:0] WIN_W = (COORD_W+1)'(IMG_W << SCALE_LOG2);
   localparam logic [COORD_W:0] WIN_H = (COORD_W+1)'(IMG_H << SCALE_LOG2);

   logic [COORD_W-1:0] pos_x;
   logic [COORD_W-1:0] pos_y;
   logic [COORD_W:0]   rx;
   logic [COORD_W:0]   ry;
   logic [ADDR_W-1:0]  src_x;
   logic [ADDR_W-1:0]  src_y;
   logic [ADDR_W-1:0]  addr_next;
   logic               inside_s1;
   logic               inside_s2;
   logic [2:0]         sync_s2;

   // Offsets are one bit wider than the coordinates, so the top bit works as
   // a sign bit. Pixels above or to the left of the window are then negative
   // and count as outside, so the window never wraps around.
   always_comb begin
      rx        = {1'b0, pix_x} - {1'b0, pos_x};
      ry        = {1'b0, pix_y} - {1'b0, pos_y};
      inside_s1 = !rx[COORD_W] && (rx < WIN_W) && !ry[COORD_W] && (ry < WIN_H);
      src_x     = ADDR_W'(rx >> SCALE_LOG2);
      src_y     = ADDR_W'(ry >> SCALE_LOG2);
      addr_next = '0;
      if (inside_s1) begin
         addr_next = ADDR_W'(src_y * ADDR_W'(IMG_W)) + src_x;
      end
   end

   // Stage 1.
   // The window position changes only on frame_start, so a position update
   // cannot tear the image in the middle of a frame. The ROM address is
   // registered here so the ROM sees a stable value at the next edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         pos_x    <= '0;
         pos_y    <= '0;
         rom_addr <= '0;
      end else begin
         if (frame_start) begin
            pos_x <= pos_x_req;
            pos_y <= pos_y_req;
         end
         rom_addr <= addr_next;
      end
   end

   // The inside flag and the timing flags go through two delay stages. This
   // puts them level with rom_data when the colour is picked at stage 3.
   vga_sync_delay #(
      .DEPTH     (2),
      .WIDTH     (1),
      .RESET_VAL (1'b0)
   ) u_inside_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (inside_s1),
      .dout (inside_s2)
   );

   vga_sync_delay #(
      .DEPTH     (2),
      .WIDTH     (3),
      .RESET_VAL (3'b110)
   ) u_sync_delay (
      .clk  (clk),
      .rst  (rst),
      .din  ({hsync_in, vsync_in, video_on}),
      .dout (sync_s2)
   );

   // Stage 3.
   // Blanking always outputs black. Pixels outside the window, and the
   // transparent index, show the background. Every other pixel passes the
   // ROM value through.
   always_ff @(posedge clk) begin
      if (rst) begin
         color_idx    <= '0;
         hsync_out    <= 1'b1;
         vsync_out    <= 1'b1;
         video_on_out <= 1'b0;
      end else begin
         {hsync_out, vsync_out, video_on_out} <= sync_s2;
         if (!sync_s2[0]) begin
            color_idx <= '0;
         end else if (!inside_s2) begin
            color_idx <= BG_IDX;
         end else if (rom_data == TRANSP_IDX) begin
            color_idx <= BG_IDX;
         end else begin
            color_idx <= rom_data;
         end
      end
   end

endmodule

// File: tb/tb_sprite_index_fetch.sv
// ---------------------------------------------------------------------------
// tb_sprite_index_fetch
// Directed testbench for sprite_index_fetch. A small synchronous ROM model
// returns:
//   address 0     -> 3
//   address 161   -> 6
//   address 162   -> 5 (transparent)
//   anything else -> 2
// Expected addresses and colours below are worked out by hand.
// ---------------------------------------------------------------------------
module tb_sprite_index_fetch;
   import vga_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  pix_x, pix_y, pos_x_req, pos_y_req;
   logic        video_on, hsync_in, vsync_in, frame_start;
   logic [14:0] rom_addr;
   logic [2:0]  rom_data;
   color_idx_t  color_idx;
   logic        hsync_out, vsync_out, video_on_out;

   int n_compared   = 0;
   int n_mismatched = 0;

   sprite_index_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .video_on     (video_on),
      .hsync_in     (hsync_in),
      .vsync_in     (vsync_in),
      .frame_start  (frame_start),
      .pos_x_req    (pos_x_req),
      .pos_y_req    (pos_y_req),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .color_idx    (color_idx),
      .hsync_out    (hsync_out),
      .vsync_out    (vsync_out),
      .video_on_out (video_on_out)
   );

   always #5 clk = ~clk;

   // Synchronous ROM model: data appears one cycle after the address.
   function automatic logic [2:0] rom_fn(input logic [14:0] a);
      case (a)
         15'd0:   return 3'd3;
         15'd161: return 3'd6;
         15'd162: return 3'd5;
         default: return 3'd2;
      endcase
   endfunction

   always @(posedge clk) rom_data <= rom_fn(rom_addr);

   // Inputs change 1 time unit after the rising edge.
   // Outputs are sampled at that same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int x, input int y, input logic von);
      pix_x    = 10'(x);
      pix_y    = 10'(y);
      video_on = von;
   endtask

   task automatic load_pos(input int x, input int y);
      pos_x_req   = 10'(x);
      pos_y_req   = 10'(y);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; frame_start = 1'b1; pos_x_req = 10'd100; pos_y_req = 10'd50;
      hsync_in = 1'b0; vsync_in = 1'b0; drive(5, 5, 1'b1);
      step(); step();
      n_compared += 5;
      if (color_idx !== 3'd0) begin n_mismatched++; $display("[TB] FAIL rst_color got %0d expected 0", color_idx); end
      if (rom_addr !== 15'd0) begin n_mismatched++; $display("[TB] FAIL rst_addr got %0d expected 0", rom_addr); end
      if (hsync_out !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_hsync got %b expected 1", hsync_out); end
      if (vsync_out !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_vsync got %b expected 1", vsync_out); end
      if (video_on_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_von got %b expected 0", video_on_out); end
      rst = 1'b0; frame_start = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
      drive(0, 0, 1'b0);
      step(); step(); step();
      n_compared += 3;
      if (color_idx !== 3'd0) begin n_mismatched++; $display("[TB] FAIL idle_color got %0d expected 0", color_idx); end
      if (video_on_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL idle_von got %b expected 0", video_on_out); end
      if (hsync_out !== 1'b1) begin n_mismatched++; $display("[TB] FAIL idle_hsync got %b expected 1", hsync_out); end
      // frame_start arrived during reset, so the position must still be (0,0).
      drive(4, 4, 1'b0);
      step();
      n_compared++;
      if (rom_addr !== 15'd161) begin n_mismatched++; $display("[TB] FAIL rst_pos_addr got %0d expected 161", rom_addr); end
   endtask

   task automatic test_position_load();
      load_pos(100, 50);
      drive(100, 50, 1'b1); step();
      n_compared++;
      if (rom_addr !== 15'd0) begin n_mismatched++; $display("[TB] FAIL load_origin got %0d expected 0", rom_addr); end
      drive(107, 54, 1'b1); step();
      n_compared++;
      if (rom_addr !== 15'd161) begin n_mismatched++; $display("[TB] FAIL load_161 got %0d expected 161", rom_addr); end
      drive(739, 529, 1'b1); step();
      n_compared++;
      if (rom_addr !== 15'd19199) begin n_mismatched++; $display("[TB] FAIL load_corner got %0d expected 19199", rom_addr); end
      load_pos(480, 360);
      drive(639, 479, 1'b1); step();
      n_compared++;
      if (rom_addr !== 15'd4679) begin n_mismatched++; $display("[TB] FAIL offscreen_addr got %0d expected 4679", rom_addr); end
      load_pos(100, 50);
   endtask

   task automatic test_latency_transparency();
      int xs[4]  = '{99, 107, 111, 100};
      int ys[4]  = '{54, 54, 54, 50};
      int ads[4] = '{0, 161, 162, 0};
      int cs[4]  = '{0, 6, 0, 3};
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive(xs[i], ys[i], 1'b1);
         else drive(0, 0, 1'b0);
         step();
         if (i < 4) begin
            n_compared++;
            if (rom_addr !== 15'(ads[i])) begin n_mismatched++; $display("[TB] FAIL lat_addr[%0d] got %0d expected %0d", i, rom_addr, ads[i]); end
         end
         if (i >= 2) begin
            n_compared++;
            if (color_idx !== 3'(cs[i-2])) begin n_mismatched++; $display("[TB] FAIL lat_color[%0d] got %0d expected %0d", i-2, color_idx, cs[i-2]); end
         end
      end
   endtask

   task automatic test_window_edges();
      int xs[5]  = '{740, 739, 100, 100, 100};
      int ys[5]  = '{50, 50, 49, 530, 529};
      int ads[5] = '{0, 159, 0, 0, 19040};
      int cs[5]  = '{0, 2, 0, 0, 2};
      for (int i = 0; i < 7; i++) begin
         if (i < 5) drive(xs[i], ys[i], 1'b1);
         else drive(0, 0, 1'b0);
         step();
         if (i < 5) begin
            n_compared++;
            if (rom_addr !== 15'(ads[i])) begin n_mismatched++; $display("[TB] FAIL edge_addr[%0d] got %0d expected %0d", i, rom_addr, ads[i]); end
         end
         if (i >= 2) begin
            n_compared++;
            if (color_idx !== 3'(cs[i-2])) begin n_mismatched++; $display("[TB] FAIL edge_color[%0d] got %0d expected %0d", i-2, color_idx, cs[i-2]); end
         end
      end
   endtask

   task automatic test_pos_hold();
      pos_x_req = 10'd200; pos_y_req = 10'd200;
      drive(107, 54, 1'b1); step();
      n_compared++;
      if (rom_addr !== 15'd161) begin n_mismatched++; $display("[TB] FAIL hold_addr got %0d expected 161", rom_addr); end
      load_pos(200, 200);
      drive(200, 200, 1'b1); step();
      n_compared++;
      if (rom_addr !== 15'd0) begin n_mismatched++; $display("[TB] FAIL reload_origin got %0d expected 0", rom_addr); end
      drive(207, 204, 1'b1); step();
      n_compared++;
      if (rom_addr !== 15'd161) begin n_mismatched++; $display("[TB] FAIL reload_161 got %0d expected 161", rom_addr); end
      load_pos(100, 50);
   endtask

   task automatic test_sync_align();
      logic hs_h[120], vs_h[120], von_h[120];
      int   low_cnt = 0;
      for (int n = 0; n < 120; n++) begin
         hs_h[n]  = !(n >= 5 && n < 101);
         vs_h[n]  = !(n >= 20 && n < 23);
         von_h[n] = (n >= 30 && n < 60);
         hsync_in = hs_h[n]; vsync_in = vs_h[n];
         drive(107, 54, von_h[n]);
         step();
         if (!hsync_out) low_cnt++;
         if (n >= 2) begin
            n_compared += 4;
            if (hsync_out !== hs_h[n-2]) begin n_mismatched++; $display("[TB] FAIL sync_hs[%0d] got %b expected %b", n, hsync_out, hs_h[n-2]); end
            if (vsync_out !== vs_h[n-2]) begin n_mismatched++; $display("[TB] FAIL sync_vs[%0d] got %b expected %b", n, vsync_out, vs_h[n-2]); end
            if (video_on_out !== von_h[n-2]) begin n_mismatched++; $display("[TB] FAIL sync_von[%0d] got %b expected %b", n, video_on_out, von_h[n-2]); end
            if (color_idx !== (von_h[n-2] ? 3'd6 : 3'd0)) begin n_mismatched++; $display("[TB] FAIL sync_color[%0d] got %0d expected %0d", n, color_idx, von_h[n-2] ? 6 : 0); end
         end
      end
      n_compared++;
      if (low_cnt != 96) begin n_mismatched++; $display("[TB] FAIL hs_width got %0d expected 96", low_cnt); end
   endtask

   task automatic test_reset_midframe();
      hsync_in = 1'b1; vsync_in = 1'b1;
      drive(107, 54, 1'b1);
      step(); step(); step();
      n_compared++;
      if (color_idx !== 3'd6) begin n_mismatched++; $display("[TB] FAIL pre_rst_color got %0d expected 6", color_idx); end
      rst = 1'b1; step();
      n_compared += 3;
      if (color_idx !== 3'd0) begin n_mismatched++; $display("[TB] FAIL mid_rst_color got %0d expected 0", color_idx); end
      if (rom_addr !== 15'd0) begin n_mismatched++; $display("[TB] FAIL mid_rst_addr got %0d expected 0", rom_addr); end
      if (video_on_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_rst_von got %b expected 0", video_on_out); end
      rst = 1'b0; step();
      n_compared += 2;
      if (rom_addr !== 15'd2106) begin n_mismatched++; $display("[TB] FAIL post_rst_addr got %0d expected 2106", rom_addr); end
      if (video_on_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL post_rst_von1 got %b expected 0", video_on_out); end
      step();
      n_compared++;
      if (video_on_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL post_rst_von2 got %b expected 0", video_on_out); end
      step();
      n_compared += 2;
      if (video_on_out !== 1'b1) begin n_mismatched++; $display("[TB] FAIL post_rst_von3 got %b expected 1", video_on_out); end
      if (color_idx !== 3'd2) begin n_mismatched++; $display("[TB] FAIL post_rst_color got %0d expected 2", color_idx); end
   endtask

   initial begin
      $display("[TB] sprite_index_fetch bench start");
      test_reset();
      test_position_load();
      test_latency_transparency();
      test_window_edges();
      test_pos_hold();
      test_sync_align();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
